// File: rtl/core_sequencer.sv
`timescale 1ns/1ps
// Multi-cycle instruction sequencer: walks one instruction through the stage units,
// skips stages the decoded class does not need, retires with a PC update and counts retirements.
module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 stat_instruction_fetched,
    input  logic                 stat_instruction_decoded,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_branch,
    input  logic                 is_jump,
    input  logic                 stat_execute_done,
    input  logic                 branch_taken,
    input  logic                 stat_mem_done,
    input  logic                 stat_writeback_done,
    output logic                 ctrl_fetch_enable,
    output logic                 ctrl_decode_enable,
    output logic                 ctrl_execute_enable,
    output logic                 ctrl_mem_enable,
    output logic                 ctrl_writeback_enable,
    output logic                 ctrl_pc_update,
    output logic                 ctrl_pc_sel,
    output logic                 busy,
    output logic                 halted,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [3:0]           state
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXECUTE   = 4'd3;
    localparam logic [3:0] S_MEMORY    = 4'd4;
    localparam logic [3:0] S_WRITEBACK = 4'd5;
    localparam logic [3:0] S_RETIRE    = 4'd6;
    localparam logic [3:0] S_HALTED    = 4'd7;
    localparam logic [3:0] S_ERROR     = 4'd8;

    logic [3:0]           r_state;
    logic [WAIT_W-1:0]    r_wait;
    logic                 r_load;
    logic                 r_store;
    logic                 r_branch;
    logic                 r_jump;
    logic                 r_taken;
    logic                 r_halt_pending;
    logic [4:0]           r_stage_en;
    logic                 r_pc_update;
    logic                 r_pc_sel;
    logic                 r_busy;
    logic                 r_halted;
    logic                 r_error;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_stat;
    logic                 w_in_stage;
    logic                 w_issue;
    logic                 w_timeout;
    logic                 w_accept;
    logic [3:0]           w_after_stage;
    logic [3:0]           w_next;
    logic                 w_enter;
    logic                 w_taken;
    logic [4:0]           w_stage_hit;

    assign w_in_stage = (r_state >= S_FETCH) && (r_state <= S_WRITEBACK);
    // r_wait is zero only in the issue cycle of a stage, so it doubles as the issue marker.
    assign w_issue    = (r_wait == '0);
    assign w_timeout  = (r_wait == WAIT_W'(TIMEOUT_CYCLES));
    assign w_accept   = w_in_stage && !w_issue && w_stat;
    assign w_enter    = (w_next != r_state);
    assign w_taken    = (r_state == S_EXECUTE) ? branch_taken : r_taken;

    always_comb begin
        w_stat        = 1'b0;
        w_after_stage = S_ERROR;
        case (r_state)
            S_FETCH: begin
                w_stat        = stat_instruction_fetched;
                w_after_stage = S_DECODE;
            end
            S_DECODE: begin
                w_stat        = stat_instruction_decoded;
                w_after_stage = S_EXECUTE;
            end
            S_EXECUTE: begin
                w_stat = stat_execute_done;
                if (r_load || r_store) begin
                    w_after_stage = S_MEMORY;
                end else if (r_branch) begin
                    w_after_stage = S_RETIRE;
                end else begin
                    w_after_stage = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                w_stat        = stat_mem_done;
                w_after_stage = r_load ? S_WRITEBACK : S_RETIRE;
            end
            S_WRITEBACK: begin
                w_stat        = stat_writeback_done;
                w_after_stage = S_RETIRE;
            end
            default: begin
                w_stat        = 1'b0;
                w_after_stage = S_ERROR;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK: begin
                // A stat in the timeout cycle still counts, so it is tested first.
                if (!w_issue) begin
                    if (w_stat) begin
                        w_next = w_after_stage;
                    end else if (w_timeout) begin
                        w_next = S_ERROR;
                    end
                end
            end
            S_RETIRE: begin
                w_next = r_halt_pending ? S_HALTED : S_FETCH;
            end
            S_ERROR: begin
                w_next = S_ERROR;
            end
            default: begin
                w_next = S_ERROR;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_stage_hit
            assign w_stage_hit[gi] = w_enter && (w_next == 4'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_wait         <= '0;
            r_load         <= 1'b0;
            r_store        <= 1'b0;
            r_branch       <= 1'b0;
            r_jump         <= 1'b0;
            r_taken        <= 1'b0;
            r_halt_pending <= 1'b0;
            r_stage_en     <= '0;
            r_pc_update    <= 1'b0;
            r_pc_sel       <= 1'b0;
            r_busy         <= 1'b0;
            r_halted       <= 1'b0;
            r_error        <= 1'b0;
            r_count        <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_enter || !w_in_stage) ? '0 : r_wait + 1'b1;

            // Class flags are reduced to one-hot with load > store > branch > jump.
            if (w_accept && (r_state == S_DECODE)) begin
                r_load   <= is_load;
                r_store  <= is_store & ~is_load;
                r_branch <= is_branch & ~is_load & ~is_store;
                r_jump   <= is_jump & ~(is_load | is_store | is_branch);
            end
            if (w_accept && (r_state == S_EXECUTE)) begin
                r_taken <= branch_taken;
            end

            r_stage_en  <= w_stage_hit;
            r_pc_update <= (w_next == S_RETIRE);
            r_pc_sel    <= (w_next == S_RETIRE) && (r_jump || (r_branch && w_taken));
            if (w_next == S_RETIRE) begin
                r_count <= r_count + 1'b1;
            end

            r_busy   <= (w_next >= S_FETCH) && (w_next <= S_RETIRE);
            r_halted <= (w_next == S_HALTED);
            r_error  <= (w_next == S_ERROR);

            if (w_next == S_HALTED) begin
                r_halt_pending <= 1'b0;
            end else if (halt_req && r_busy) begin
                r_halt_pending <= 1'b1;
            end
        end
    end

    assign ctrl_fetch_enable     = r_stage_en[0];
    assign ctrl_decode_enable    = r_stage_en[1];
    assign ctrl_execute_enable   = r_stage_en[2];
    assign ctrl_mem_enable       = r_stage_en[3];
    assign ctrl_writeback_enable = r_stage_en[4];
    assign ctrl_pc_update        = r_pc_update;
    assign ctrl_pc_sel           = r_pc_sel;
    assign busy                  = r_busy;
    assign halted                = r_halted;
    assign error                 = r_error;
    assign retired_count         = r_count;
    assign state                 = r_state;

endmodule

// File: tb/tb_core_sequencer.sv
`timescale 1ns/1ps
// Bench for core_sequencer: builds a per-cycle stimulus/expectation table from the
// instruction-level rules, replays it and compares every output on every cycle.
module tb_core_sequencer;

    localparam int TO   = 4;
    localparam int CW   = 2;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic halt_req = 1'b0;
    logic stat_instruction_fetched = 1'b0;
    logic stat_instruction_decoded = 1'b0;
    logic is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jump = 1'b0;
    logic stat_execute_done = 1'b0;
    logic branch_taken = 1'b0;
    logic stat_mem_done = 1'b0;
    logic stat_writeback_done = 1'b0;

    logic ctrl_fetch_enable, ctrl_decode_enable, ctrl_execute_enable;
    logic ctrl_mem_enable, ctrl_writeback_enable, ctrl_pc_update, ctrl_pc_sel;
    logic busy, halted, error;
    logic [CW-1:0] retired_count;
    logic [3:0] state;

    always #5 clk = ~clk;

    core_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .stat_instruction_fetched(stat_instruction_fetched),
        .stat_instruction_decoded(stat_instruction_decoded),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
        .stat_execute_done(stat_execute_done), .branch_taken(branch_taken),
        .stat_mem_done(stat_mem_done), .stat_writeback_done(stat_writeback_done),
        .ctrl_fetch_enable(ctrl_fetch_enable), .ctrl_decode_enable(ctrl_decode_enable),
        .ctrl_execute_enable(ctrl_execute_enable), .ctrl_mem_enable(ctrl_mem_enable),
        .ctrl_writeback_enable(ctrl_writeback_enable), .ctrl_pc_update(ctrl_pc_update),
        .ctrl_pc_sel(ctrl_pc_sel), .busy(busy), .halted(halted), .error(error),
        .retired_count(retired_count), .state(state)
    );

    // Per-cycle stimulus (st_*) and expected outputs (ex_*).
    logic          st_start [MAXC];
    logic          st_halt  [MAXC];
    logic [4:0]    st_stat  [MAXC];
    logic [3:0]    st_cls   [MAXC];
    logic          st_taken [MAXC];
    logic [3:0]    ex_state [MAXC];
    logic [4:0]    ex_en    [MAXC];
    logic          ex_pcu   [MAXC];
    logic          ex_pcsel [MAXC];
    logic          ex_busy  [MAXC];
    logic          ex_halted[MAXC];
    logic          ex_error [MAXC];
    logic [CW-1:0] ex_cnt   [MAXC];

    int      n_cyc;
    int      cyc;
    bit      checking = 1'b0;
    int      checks = 0;
    int      errors = 0;
    logic [CW-1:0] m_cnt;
    bit      m_pending;
    bit      g_quiet;
    int      f_idx [8];
    int      r_idx [8];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic add_cycle(input logic [3:0] st, input logic [4:0] en, input logic pcu,
                             input logic pcsel, output int idx);
        if (n_cyc >= MAXC) begin
            $display("FAIL table_overflow: got %0d cycles, limit %0d", n_cyc, MAXC);
            $fatal(1);
        end
        idx = n_cyc;
        ex_state[idx]  = st;
        ex_en[idx]     = en;
        ex_pcu[idx]    = pcu;
        ex_pcsel[idx]  = pcsel;
        ex_busy[idx]   = (st >= 4'd1) && (st <= 4'd6);
        ex_halted[idx] = (st == 4'd7);
        ex_error[idx]  = (st == 4'd8);
        ex_cnt[idx]    = m_cnt;
        st_start[idx]  = (st == 4'd0 || st == 4'd7) ? 1'b0 : 1'($urandom % 2);
        st_halt[idx]   = g_quiet ? 1'b0 : ($urandom % 40 == 0);
        for (int b = 0; b < 5; b++) st_stat[idx][b] = ($urandom % 4 == 0);
        st_cls[idx]    = 4'($urandom % 16);
        st_taken[idx]  = 1'($urandom % 2);
        n_cyc++;
    endtask

    // One stage occupancy: issue cycle plus k waiting cycles; stat on the k-th unless withheld.
    task automatic stage(input int s, input int k, input logic [3:0] cls, input logic taken,
                         input bit withhold, input bit halt_at_issue, output int issue_idx);
        int idx;
        issue_idx = n_cyc;
        for (int j = 0; j <= k; j++) begin
            add_cycle(4'(s + 1), (j == 0) ? 5'(1 << s) : 5'd0, 1'b0, 1'b0, idx);
            if (j == 0) begin
                if (halt_at_issue) st_halt[idx] = 1'b1;
            end else begin
                st_stat[idx][s] = (j == k) && !withhold;
                if (j == k && !withhold) begin
                    if (s == 1) st_cls[idx] = cls;
                    if (s == 2) st_taken[idx] = taken;
                end
            end
            if (st_halt[idx]) m_pending = 1'b1;
        end
    endtask

    task automatic idle_phase(input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            add_cycle(4'd0, 5'd0, 1'b0, 1'b0, idx);
            st_start[idx] = (i == n - 1);
        end
    endtask

    // lat_mode 0: random stage latencies; otherwise every stat answers lat_mode cycles after issue.
    task automatic instr(input logic [3:0] cls, input logic taken, input int lat_mode,
                         input bit halt_dec, output int fi, output int ri);
        bit ld, sv, br, jp;
        int lat [5];
        int dummy, idx, hold;
        ld = cls[3];
        sv = cls[2] & !cls[3];
        br = cls[1] & !cls[3] & !cls[2];
        jp = cls[0] & !cls[3] & !cls[2] & !cls[1];
        for (int s = 0; s < 5; s++)
            lat[s] = (lat_mode != 0) ? lat_mode :
                     (($urandom % 3 == 0) ? int'($urandom_range(1, TO)) : 1);
        stage(0, lat[0], cls, taken, 1'b0, 1'b0, fi);
        stage(1, lat[1], cls, taken, 1'b0, halt_dec, dummy);
        stage(2, lat[2], cls, taken, 1'b0, 1'b0, dummy);
        if (ld || sv) stage(3, lat[3], cls, taken, 1'b0, 1'b0, dummy);
        if (ld || (!sv && !br)) stage(4, lat[4], cls, taken, 1'b0, 1'b0, dummy);
        m_cnt = m_cnt + 1'b1;
        add_cycle(4'd6, 5'd0, 1'b1, jp | (br & taken), ri);
        if (m_pending) begin
            m_pending = 1'b0;
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                add_cycle(4'd7, 5'd0, 1'b0, 1'b0, idx);
                st_start[idx] = (h == hold - 1);
            end
        end else if (st_halt[ri]) begin
            m_pending = 1'b1;
        end
    endtask

    task automatic apply(input int c);
        start    = st_start[c];
        halt_req = st_halt[c];
        {stat_writeback_done, stat_mem_done, stat_execute_done,
         stat_instruction_decoded, stat_instruction_fetched} = st_stat[c];
        {is_load, is_store, is_branch, is_jump} = st_cls[c];
        branch_taken = st_taken[c];
    endtask

    task automatic check_zero(input string name);
        chk(name, int'({ctrl_fetch_enable, ctrl_decode_enable, ctrl_execute_enable,
                        ctrl_mem_enable, ctrl_writeback_enable, ctrl_pc_update, ctrl_pc_sel,
                        busy, halted, error, retired_count, state}), 0);
    endtask

    task automatic run_table();
        reset = 1'b1;
        apply(0);
        repeat (2) @(posedge clk);
        #1 check_zero("reset_outputs");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        apply(0);
        checking = 1'b1;
        for (int c = 1; c < n_cyc; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            apply(c);
        end
        @(negedge clk);
        #1 checking = 1'b0;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("state", int'(state), int'(ex_state[cyc]));
            chk("stage_enables", int'({ctrl_writeback_enable, ctrl_mem_enable, ctrl_execute_enable,
                                       ctrl_decode_enable, ctrl_fetch_enable}), int'(ex_en[cyc]));
            chk("pc_update", int'(ctrl_pc_update), int'(ex_pcu[cyc]));
            if (ex_pcu[cyc]) chk("pc_sel", int'(ctrl_pc_sel), int'(ex_pcsel[cyc]));
            chk("busy", int'(busy), int'(ex_busy[cyc]));
            chk("halted", int'(halted), int'(ex_halted[cyc]));
            chk("error", int'(error), int'(ex_error[cyc]));
            chk("retired_count", int'(retired_count), int'(ex_cnt[cyc]));
            if (ctrl_pc_update)
                $display("retire cycle %0d: count=%0d pc_sel=%0d", cyc, retired_count, ctrl_pc_sel);
        end
    end

    initial begin
        int dummy_f, dummy_r, dummy_i;

        // Run 1: directed instructions, random program, then abort by reset mid-MEMORY.
        n_cyc = 0; m_cnt = '0; m_pending = 1'b0; g_quiet = 1'b1;
        idle_phase(3);
        instr(4'b0000, 1'b0, 1, 1'b0, f_idx[0], r_idx[0]);
        instr(4'b1000, 1'b0, 1, 1'b0, f_idx[1], r_idx[1]);
        instr(4'b0100, 1'b0, 1, 1'b0, f_idx[2], r_idx[2]);
        instr(4'b0010, 1'b1, 1, 1'b0, f_idx[3], r_idx[3]);
        instr(4'b0010, 1'b0, 1, 1'b0, f_idx[4], r_idx[4]);
        instr(4'b0001, 1'b0, 1, 1'b0, f_idx[5], r_idx[5]);
        instr(4'b0000, 1'b0, 1, 1'b1, f_idx[6], r_idx[6]);
        instr(4'b0000, 1'b0, TO, 1'b0, f_idx[7], r_idx[7]);

        // Hand-derived timing pins for the table itself.
        chk("model_rtype_fetch_gap", f_idx[1] - f_idx[0], 9);
        chk("model_load_fetch_gap", f_idx[2] - f_idx[1], 11);
        chk("model_branch_taken_fetch_gap", f_idx[4] - f_idx[3], 7);
        chk("model_branch_nt_fetch_gap", f_idx[5] - f_idx[4], 7);
        chk("model_jump_fetch_gap", f_idx[6] - f_idx[5], 9);
        chk("model_pc_sel_taken", int'(ex_pcsel[r_idx[3]]), 1);
        chk("model_pc_sel_not_taken", int'(ex_pcsel[r_idx[4]]), 0);
        chk("model_pc_sel_jump", int'(ex_pcsel[r_idx[5]]), 1);
        chk("model_count_wrap", int'(ex_cnt[r_idx[3]]), 0);
        chk("model_halt_after_retire", int'(ex_state[r_idx[6] + 1]), 7);
        chk("model_slow_rtype_fetch_gap", r_idx[7] + 1 - f_idx[7], 4 * (TO + 1) + 1);

        g_quiet = 1'b0;
        for (int i = 0; i < 30; i++)
            instr(4'($urandom % 16), 1'($urandom % 2), 0, 1'b0, dummy_f, dummy_r);
        stage(0, 1, 4'b1000, 1'b0, 1'b0, 1'b0, dummy_i);
        stage(1, 1, 4'b1000, 1'b0, 1'b0, 1'b0, dummy_i);
        stage(2, 1, 4'b1000, 1'b0, 1'b0, 1'b0, dummy_i);
        stage(3, 1, 4'b1000, 1'b0, 1'b1, 1'b0, dummy_i);
        run_table();

        // Still in the MEMORY wait cycle: asynchronous reset must clear outputs at once.
        reset = 1'b1;
        #1 check_zero("async_reset_mid_memory");
        chk("async_reset_state_idle", int'(state), 0);
        @(posedge clk);

        // Run 2: a few instructions, then execute stat withheld until timeout.
        n_cyc = 0; m_cnt = '0; m_pending = 1'b0; g_quiet = 1'b0;
        idle_phase(2);
        for (int i = 0; i < 3; i++)
            instr(4'($urandom % 16), 1'($urandom % 2), 0, 1'b0, dummy_f, dummy_r);
        instr(4'b0001, 1'b0, TO, 1'b0, dummy_f, dummy_r);
        stage(0, 1, 4'b0000, 1'b0, 1'b0, 1'b0, dummy_i);
        stage(1, 1, 4'b0000, 1'b0, 1'b0, 1'b0, dummy_i);
        stage(2, TO, 4'b0000, 1'b0, 1'b1, 1'b0, dummy_i);
        for (int i = 0; i < 8; i++) add_cycle(4'd8, 5'd0, 1'b0, 1'b0, dummy_i);
        run_table();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
